btn_conditioner: RTL and testbench

//  Parametrised N-channel button front end; successor to the single-button Anti_jitter path.
//  Per channel: 2-FF synchroniser, debounce counter, press/release/long-press pulses, and a hold timer.
//  The hold timer is the saturating press duration in prescaled ticks (charge input for the jump FSM).

---
 rtl/btn_conditioner.sv | 181 ++++++++++++++++++
 tb/tb_btn_conditioner.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// N-channel button front end: 2-FF sync, debounce FSM, press/release/long pulses, hold timer.
// Optional auto-repeat of o_press after o_long when BTN_COND_AUTOREPEAT_EN is defined.
module btn_conditioner #(
    parameter int N_BTN        = 1,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEB_CYCLES   = 500000,
    parameter int TICK_DIV     = 1000000,
    parameter int HOLD_W       = 8,
    parameter int LONG_TICKS   = 50,
    parameter int REPEAT_TICKS = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_BTN-1:0]          i_btn,
    output logic [N_BTN-1:0]          o_level,
    output logic [N_BTN-1:0]          o_press,
    output logic [N_BTN-1:0]          o_release,
    output logic [N_BTN-1:0]          o_long,
    output logic [N_BTN*HOLD_W-1:0]   o_hold_cnt,
    output logic [N_BTN*HOLD_W-1:0]   o_hold_len
);

    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0]     DEB_LAST = DW'(DEB_CYCLES - 2);
    localparam logic [PW-1:0]     PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] LONG_M1  = HOLD_W'(LONG_TICKS - 1);
    localparam logic [N_BTN-1:0]  NORM     = (ACTIVE_LOW != 0) ? '1 : '0;

    if (DEB_CYCLES < 2 || TICK_DIV < 1 || REPEAT_TICKS < 1) begin : g_bad_param
        $error("btn_conditioner: invalid parameter value");
    end

    typedef enum logic [1:0] {REL, ARM, HELD, DISARM} state_t;

    logic [N_BTN-1:0]  sync1_q, sync_q;
    logic [PW-1:0]     pre_q;
    logic              tick;
    state_t            state_q [N_BTN];
    logic [DW-1:0]     deb_q   [N_BTN];
    logic [HOLD_W-1:0] hold_q  [N_BTN];
    logic [HOLD_W-1:0] len_q   [N_BTN];
    logic [N_BTN-1:0]  level_q, press_q, release_q, long_q;
    logic [N_BTN-1:0]  press_d, release_d, hold_inc, long_d;

`ifdef BTN_COND_AUTOREPEAT_EN
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS + 1) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
    logic [RW-1:0]    rep_q [N_BTN];
    logic [N_BTN-1:0] rep_on_q, rpt_step, rpt_d;
`endif

    always_comb begin
        tick = (pre_q == PRE_LAST);
        press_d    = '0;
        release_d  = '0;
        hold_inc   = '0;
        long_d     = '0;
        o_hold_cnt = '0;
        o_hold_len = '0;
`ifdef BTN_COND_AUTOREPEAT_EN
        rpt_step = '0;
        rpt_d    = '0;
`endif
        for (int unsigned k = 0; k < N_BTN; k++) begin
            press_d[k]   = (state_q[k] == ARM) && sync_q[k] && (deb_q[k] == DEB_LAST);
            release_d[k] = (state_q[k] == DISARM) && !sync_q[k] && (deb_q[k] == DEB_LAST);
            // The hold timer freezes on the release edge so o_hold_len equals the final o_hold_cnt.
            hold_inc[k]  = tick && (hold_q[k] != '1) &&
                           ((state_q[k] == HELD) || ((state_q[k] == DISARM) && !release_d[k]));
            long_d[k]    = hold_inc[k] && (hold_q[k] == LONG_M1);
`ifdef BTN_COND_AUTOREPEAT_EN
            rpt_step[k]  = rep_on_q[k] && tick && (state_q[k] == HELD) && sync_q[k] && !long_d[k];
            rpt_d[k]     = rpt_step[k] && (rep_q[k] == REP_LAST);
`endif
            o_hold_cnt[k*HOLD_W +: HOLD_W] = hold_q[k];
            o_hold_len[k*HOLD_W +: HOLD_W] = len_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync_q  <= '0;
            pre_q   <= '0;
        end else begin
            sync1_q <= i_btn ^ NORM;
            sync_q  <= sync1_q;
            pre_q   <= tick ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int unsigned k = 0; k < N_BTN; k++) begin
                state_q[k] <= REL;
                deb_q[k]   <= '0;
                hold_q[k]  <= '0;
                len_q[k]   <= '0;
`ifdef BTN_COND_AUTOREPEAT_EN
                rep_q[k]    <= '0;
                rep_on_q[k] <= 1'b0;
`endif
            end
        end else begin
`ifdef BTN_COND_AUTOREPEAT_EN
            press_q <= press_d | rpt_d;
`else
            press_q <= press_d;
`endif
            release_q <= release_d;
            long_q    <= long_d;
            for (int unsigned k = 0; k < N_BTN; k++) begin
                case (state_q[k])
                    REL: begin
                        deb_q[k] <= '0;
                        if (sync_q[k]) state_q[k] <= ARM;
                    end
                    ARM: begin
                        if (!sync_q[k]) begin
                            state_q[k] <= REL;
                            deb_q[k]   <= '0;
                        end else if (press_d[k]) begin
                            state_q[k] <= HELD;
                            deb_q[k]   <= '0;
                            level_q[k] <= 1'b1;
                        end else begin
                            deb_q[k] <= deb_q[k] + 1'b1;
                        end
                    end
                    HELD: begin
                        deb_q[k] <= '0;
                        if (!sync_q[k]) state_q[k] <= DISARM;
                    end
                    DISARM: begin
                        if (sync_q[k]) begin
                            state_q[k] <= HELD;
                            deb_q[k]   <= '0;
                        end else if (release_d[k]) begin
                            state_q[k] <= REL;
                            deb_q[k]   <= '0;
                            level_q[k] <= 1'b0;
                            len_q[k]   <= hold_q[k];
                        end else begin
                            deb_q[k] <= deb_q[k] + 1'b1;
                        end
                    end
                    default: begin
                        state_q[k] <= REL;
                        deb_q[k]   <= '0;
                    end
                endcase

                if (press_d[k])       hold_q[k] <= '0;
                else if (hold_inc[k]) hold_q[k] <= hold_q[k] + 1'b1;

`ifdef BTN_COND_AUTOREPEAT_EN
                if (press_d[k]) begin
                    rep_on_q[k] <= 1'b0;
                    rep_q[k]    <= '0;
                end else if (long_d[k]) begin
                    rep_on_q[k] <= 1'b1;
                    rep_q[k]    <= '0;
                end else if (rpt_step[k]) begin
                    rep_q[k] <= rpt_d[k] ? '0 : rep_q[k] + 1'b1;
                end
`endif
            end
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed vector table, corner sequences,
// and random stimulus against a run-length reference model.
module tb_btn_conditioner;

    localparam int N = 2, DEB = 4, TDIV = 3, HW = 4, LONG = 5, REP = 2;
    localparam int HMAX = (1 << HW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    i_btn = '1;
    logic [N-1:0]    o_level, o_press, o_release, o_long;
    logic [N*HW-1:0] o_hold_cnt, o_hold_len;

    int checks = 0;
    int failures = 0;

    btn_conditioner #(
        .N_BTN(N), .ACTIVE_LOW(1), .DEB_CYCLES(DEB), .TICK_DIV(TDIV),
        .HOLD_W(HW), .LONG_TICKS(LONG), .REPEAT_TICKS(REP)
    ) dut (
        .clk(clk), .rst(rst), .i_btn(i_btn),
        .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_long(o_long),
        .o_hold_cnt(o_hold_cnt), .o_hold_len(o_hold_len)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips once the synchronised input has disagreed with it
    // for DEB consecutive cycles; the hold timer counts prescaler ticks while pressed.
    int m_s1 [N], m_s2 [N], m_run [N], m_lvl [N], m_hold [N], m_len [N];
    int m_rep [N], m_repon [N];
    int m_edge;
    logic [N-1:0]    e_lvl, e_prs, e_rls, e_lng;
    logic [N*HW-1:0] e_hold, e_len;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_run[c] = 0; m_lvl[c] = 0;
            m_hold[c] = 0; m_len[c] = 0; m_rep[c] = 0; m_repon[c] = 0;
        end
        m_edge = 0;
        e_lvl = '0; e_prs = '0; e_rls = '0; e_lng = '0; e_hold = '0; e_len = '0;
    endtask

    task automatic model_step();
        bit tk;
        tk = (m_edge % TDIV) == TDIV - 1;
        m_edge++;
        for (int c = 0; c < N; c++) begin
            int s;
            bit p, r, l, held, acc;
            s = m_s2[c];
            p = 0; r = 0; l = 0;
            held = (m_lvl[c] == 1) && (m_run[c] == 0);
            if (s != m_lvl[c]) m_run[c]++;
            else               m_run[c] = 0;
            acc = (m_run[c] == DEB);
            if (acc) m_run[c] = 0;
            if (acc && m_lvl[c] == 0) begin
                p = 1; m_lvl[c] = 1; m_hold[c] = 0; m_repon[c] = 0; m_rep[c] = 0;
            end else if (acc) begin
                r = 1; m_lvl[c] = 0; m_len[c] = m_hold[c];
            end else if (m_lvl[c] == 1 && tk) begin
                if (m_hold[c] < HMAX) begin
                    m_hold[c]++;
                    if (m_hold[c] == LONG) begin
                        l = 1; m_repon[c] = 1; m_rep[c] = 0;
                    end
                end
`ifdef BTN_COND_AUTOREPEAT_EN
                if (!l && m_repon[c] == 1 && held && s == 1) begin
                    m_rep[c]++;
                    if (m_rep[c] == REP) begin
                        p = 1; m_rep[c] = 0;
                    end
                end
`endif
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = i_btn[c] ? 0 : 1;
            e_lvl[c] = m_lvl[c][0]; e_prs[c] = p; e_rls[c] = r; e_lng[c] = l;
            e_hold[c*HW +: HW] = HW'(m_hold[c]);
            e_len[c*HW +: HW]  = HW'(m_len[c]);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".level"},   32'(o_level),    32'(e_lvl));
        chk({tag, ".press"},   32'(o_press),    32'(e_prs));
        chk({tag, ".release"}, 32'(o_release),  32'(e_rls));
        chk({tag, ".long"},    32'(o_long),     32'(e_lng));
        chk({tag, ".hold"},    32'(o_hold_cnt), 32'(e_hold));
        chk({tag, ".len"},     32'(o_hold_len), 32'(e_len));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".zero"}, 32'({o_level, o_press, o_release, o_long, o_hold_cnt, o_hold_len}), 32'd0);
    endtask

    task automatic cycle(input logic [N-1:0] b);
        i_btn = b;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        i_btn = '1;
        rst = 1'b1;
        #1;
        check_zero("reset_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("reset_held");
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0]    btn;
        logic [N-1:0]    lvl, prs, rls, lng;
        logic [N*HW-1:0] hold, len;
    } vec_t;
    vec_t tbl[$];

    // Appends n identical rows; channel 1 stays idle, so its expectations are all zero.
    task automatic add(input int n, input logic [N-1:0] b, input bit lv, input bit pr,
                       input bit rl, input bit lg, input int h, input int ln);
        vec_t v;
        v.btn = b;
        v.lvl = {1'b0, lv}; v.prs = {1'b0, pr}; v.rls = {1'b0, rl}; v.lng = {1'b0, lg};
        v.hold = {{HW{1'b0}}, HW'(h)};
        v.len  = {{HW{1'b0}}, HW'(ln)};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        int nlong, nrel, npress;
        logic [N-1:0] b;

        // Idle with buttons released: everything stays zero.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(2'b11);
            check_zero("idle");
        end

        // Directed table on channel 0: press latency, tick cadence, long, release, latched length.
        add(5, 2'b10, 0, 0, 0, 0, 0, 0);
        add(1, 2'b10, 1, 1, 0, 0, 0, 0);
        add(2, 2'b10, 1, 0, 0, 0, 0, 0);
        add(3, 2'b10, 1, 0, 0, 0, 1, 0);
        add(3, 2'b10, 1, 0, 0, 0, 2, 0);
        add(3, 2'b10, 1, 0, 0, 0, 3, 0);
        add(3, 2'b10, 1, 0, 0, 0, 4, 0);
        add(1, 2'b10, 1, 0, 0, 1, 5, 0);
        add(1, 2'b10, 1, 0, 0, 0, 5, 0);
        add(1, 2'b11, 1, 0, 0, 0, 5, 0);
        add(3, 2'b11, 1, 0, 0, 0, 6, 0);
        add(1, 2'b11, 1, 0, 0, 0, 7, 0);
        add(1, 2'b11, 0, 0, 1, 0, 7, 7);
        add(2, 2'b11, 0, 0, 0, 0, 7, 7);
        do_reset();
        foreach (tbl[i]) begin
            cycle(tbl[i].btn);
            chk("tbl.level",   32'(o_level),    32'(tbl[i].lvl));
            chk("tbl.press",   32'(o_press),    32'(tbl[i].prs));
            chk("tbl.release", 32'(o_release),  32'(tbl[i].rls));
            chk("tbl.long",    32'(o_long),     32'(tbl[i].lng));
            chk("tbl.hold",    32'(o_hold_cnt), 32'(tbl[i].hold));
            chk("tbl.len",     32'(o_hold_len), 32'(tbl[i].len));
        end

        // Pulses one cycle shorter than the debounce window are rejected.
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 6; i++) begin
                cycle(i < 3 ? 2'b01 : 2'b11);
                chk("reject.level", 32'(o_level), 32'd0);
                chk("reject.press", 32'(o_press), 32'd0);
            end
        end

        // Long hold: one o_long, saturation, latched length on release.
        do_reset();
        nlong = 0; nrel = 0;
        for (int i = 0; i < 76; i++) begin
            cycle(2'b10);
            if (o_long[0]) nlong++;
        end
        chk("long.count", 32'(nlong), 32'd1);
        chk("long.sat", 32'(o_hold_cnt[HW-1:0]), 32'(HMAX));
        for (int i = 0; i < 8; i++) begin
            cycle(2'b11);
            if (o_release[0]) nrel++;
        end
        chk("long.rel_count", 32'(nrel), 32'd1);
        chk("long.len", 32'(o_hold_len[HW-1:0]), 32'(HMAX));
        chk("long.level", 32'(o_level), 32'd0);
        chk("long.cnt_kept", 32'(o_hold_cnt[HW-1:0]), 32'(HMAX));

        // Simultaneous press on both channels, then reset mid-hold.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(2'b00);
            chk("dual.no_press", 32'(o_press), 32'd0);
        end
        cycle(2'b00);
        chk("dual.press", 32'(o_press), 32'b11);
        cycle(2'b00);
        chk("dual.press_end", 32'(o_press), 32'd0);
        chk("dual.level", 32'(o_level), 32'b11);
        for (int i = 0; i < 10; i++) cycle(2'b00);
        chk("dual.hold_live", 32'(o_hold_cnt != '0), 32'd1);
        rst = 1'b1;
        #1;
        check_zero("midhold_reset");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_zero("midhold_reset_cyc");
        end
        do_reset();

`ifdef BTN_COND_AUTOREPEAT_EN
        // Auto-repeat: presses at hold 0, then every REP ticks after the long pulse.
        begin
            int exp_h[$] = '{0, 7, 9, 11};
            int seen[$];
            do_reset();
            for (int i = 0; i < 50; i++) begin
                cycle(2'b10);
                if (o_press[0]) seen.push_back(int'(o_hold_cnt[HW-1:0]));
            end
            chk("rpt.count_ge4", 32'(seen.size() >= 4), 32'd1);
            for (int i = 0; i < 4; i++)
                chk("rpt.hold_at_press", 32'(i < seen.size() ? seen[i] : -1), 32'(exp_h[i]));
            nrel = 0;
            for (int i = 0; i < 8 && nrel == 0; i++) begin
                cycle(2'b11);
                if (o_release[0]) nrel++;
            end
            chk("rpt.released", 32'(nrel), 32'd1);
            npress = 0;
            for (int i = 0; i < 20; i++) begin
                cycle(2'b11);
                if (o_press[0]) npress++;
            end
            chk("rpt.none_after_release", 32'(npress), 32'd0);
        end
`endif

        // Random stimulus against the reference model, with bursty short glitches.
        do_reset();
        b = '1;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, (i % 400 < 100) ? 2 : 9) == 0) b[c] = ~b[c];
            end
            cycle(b);
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
